// File: rtl/g_lut_pkg.sv
// Shared constants and types for the g-LUT round-robin arbiter.
// Optional stall statistics are enabled by defining G_LUT_ARB_STATS_EN.
package g_lut_pkg;
  localparam int PIX_W_DFLT   = 5;
  localparam int DATA_W_DFLT  = 8;
  localparam int NUM_REQ_DFLT = 3;
  localparam int REQ_IDX_W    = $clog2(NUM_REQ_DFLT);

  typedef logic [REQ_IDX_W-1:0] req_idx_t;
endpackage

// File: rtl/g_lut_arbiter_rr.sv
// Round-robin grant logic with a rotating priority pointer.
// The search starts one past the last winner; the pointer moves only on a grant.
module rr_arbiter
  import g_lut_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DFLT,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               gnt_any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    idx_o     = '0;
    gnt_any_o = 1'b0;
    cand      = '0;
    ptr_d     = ptr_q;
    if (en_i) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
        if (!gnt_any_o && req_i[cand]) begin
          gnt_o[cand] = 1'b1;
          idx_o       = cand;
          gnt_any_o   = 1'b1;
        end
      end
    end
    if (gnt_any_o) ptr_d = idx_o;
  end

  // Reset pointer to the last stream so stream 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(NUM_REQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/g_lut_arbiter.sv
// Time-shares one registered camera-response LUT between NUM_REQ exposure streams.
// Define G_LUT_ARB_STATS_EN to enable the saturating stall_cnt counter.
module g_lut_arbiter
  import g_lut_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DFLT,
  parameter int PIX_W   = PIX_W_DFLT,
  parameter int DATA_W  = DATA_W_DFLT,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PIX_W-1:0] req_pixel,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [PIX_W-1:0]         lut_pixel,
  output logic                     lut_clk_en,
  input  logic [DATA_W-1:0]        lut_data,
  output logic [15:0]              stall_cnt
);

  logic               s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]   s1_tag_q, s1_tag_d;
  logic               advance;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;

  assign advance    = !s1_valid_q || rsp_ready[s1_tag_q];
  assign lut_clk_en = advance;
  assign req_ready  = gnt;
  assign rsp_data   = lut_data;

  // S0: arbitration; grants are suppressed while reset is asserted.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_valid),
    .en_i     (advance && rst_n),
    .gnt_o    (gnt),
    .idx_o    (gnt_idx),
    .gnt_any_o(gnt_any)
  );

  always_comb begin
    lut_pixel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) lut_pixel = req_pixel[i*PIX_W +: PIX_W];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_tag_d   = s1_tag_q;
    if (advance) begin
      s1_valid_d = gnt_any;
      s1_tag_d   = gnt_idx;
    end
  end

  // S1: tag/valid registers alongside the LUT output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = s1_valid_q && (s1_tag_q == IDX_W'(i));
  end

`ifdef G_LUT_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (s1_valid_q && !advance && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_g_lut_arbiter.sv
// Bench for g_lut_arbiter: directed scenarios plus constrained-random traffic
// against a cycle reference model of the arbitration rules, and a NUM_REQ=2 instance.
module tb_g_lut_arbiter;
  localparam int N  = 3;
  localparam int PW = 5;
  localparam int DW = 8;
`ifdef G_LUT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*PW-1:0] req_pixel;
  logic [DW-1:0]   rsp_data, lut_data;
  logic [PW-1:0]   lut_pixel;
  logic            lut_clk_en;
  logic [15:0]     stall_cnt;

  logic [1:0]      r2_valid, r2_ready, r2_rsp_valid, r2_rsp_ready;
  logic [2*PW-1:0] r2_pixel;
  logic [DW-1:0]   r2_rsp_data, r2_lut_data;
  logic [PW-1:0]   r2_lut_pixel;
  logic            r2_clk_en;
  logic [15:0]     r2_stall;

  logic [7:0] lut_tab [32];

  int total = 0;
  int bad   = 0;

  int m_ptr, m_s1v, m_tag, m_pix, m_stall;
  logic [N-1:0] m_last_gnt;
  int gnt_log[$];

  always #5 clk = ~clk;

  // External LUT models: registered, clock-enabled, no reset.
  always @(posedge clk) if (lut_clk_en) lut_data <= lut_tab[lut_pixel];
  always @(posedge clk) if (r2_clk_en) r2_lut_data <= lut_tab[r2_lut_pixel];

  g_lut_arbiter #(.NUM_REQ(N), .PIX_W(PW), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_pixel(req_pixel), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .lut_pixel(lut_pixel), .lut_clk_en(lut_clk_en), .lut_data(lut_data),
    .stall_cnt(stall_cnt)
  );

  g_lut_arbiter #(.NUM_REQ(2), .PIX_W(PW), .DATA_W(DW)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r2_valid), .req_pixel(r2_pixel), .req_ready(r2_ready),
    .rsp_valid(r2_rsp_valid), .rsp_ready(r2_rsp_ready), .rsp_data(r2_rsp_data),
    .lut_pixel(r2_lut_pixel), .lut_clk_en(r2_clk_en), .lut_data(r2_lut_data),
    .stall_cnt(r2_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = N - 1; m_s1v = 0; m_tag = 0; m_pix = 0; m_stall = 0;
    m_last_gnt = '0;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic step();
    int adv, win;
    logic [N-1:0]  exp_rdy;
    logic [PW-1:0] exp_pix;
    @(negedge clk);
    adv = (m_s1v == 0 || rsp_ready[m_tag]) ? 1 : 0;
    win = -1;
    if (adv != 0)
      for (int k = 1; k <= N; k++) begin
        int c = (m_ptr + k) % N;
        if (win < 0 && req_valid[c]) win = c;
      end
    exp_rdy = (win >= 0) ? N'(1 << win) : '0;
    exp_pix = (win >= 0) ? req_pixel[win*PW +: PW] : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("lut_pixel", lut_pixel, exp_pix);
    chk("lut_clk_en", lut_clk_en, adv);
    chk("rsp_valid", rsp_valid, (m_s1v != 0) ? (1 << m_tag) : 0);
    if (m_s1v != 0) chk("rsp_data", rsp_data, lut_tab[m_pix]);
    chk("stall_cnt", stall_cnt, m_stall);
    if (STATS && m_s1v != 0 && adv == 0 && m_stall < 16'hFFFF) m_stall++;
    m_last_gnt = exp_rdy;
    if (adv != 0) begin
      m_s1v = (win >= 0) ? 1 : 0;
      if (win >= 0) begin
        m_tag = win; m_pix = exp_pix; m_ptr = win;
        gnt_log.push_back(win);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_lut_pixel"}, lut_pixel, 0);
    chk({tag, "_clk_en"}, lut_clk_en, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt[N];
    for (int p = 0; p < 32; p++) lut_tab[p] = 8'(p * 5 + 3);
    lut_tab[0] = 8'h00; lut_tab[1] = 8'h09; lut_tab[16] = 8'h32;
    lut_tab[24] = 8'h40; lut_tab[31] = 8'h51;

    req_valid = '0; req_pixel = '0; rsp_ready = '1;
    r2_valid = '0; r2_pixel = '0; r2_rsp_ready = '1;
    model_reset();

    // Reset state, with requests present to confirm no grant during reset.
    @(posedge clk); #1;
    req_valid = 3'b111;
    @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_stall", stall_cnt, 0);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();

    // Three streams, fixed pixels: grants 0,1,2 and responses 09/32/51.
    gnt_log.delete();
    req_pixel = {5'h1F, 5'h10, 5'h01};
    req_valid = 3'b111;
    repeat (3) step();
    req_valid = '0;
    step();
    chk("seq_len", gnt_log.size(), 3);
    for (int i = 0; i < gnt_log.size(); i++) chk("seq_order", gnt_log[i], i);

    // Stream 1 alone, back-to-back.
    gnt_log.delete();
    req_pixel = {5'h00, 5'h18, 5'h00};
    req_valid = 3'b010;
    repeat (6) step();
    chk("solo_len", gnt_log.size(), 6);
    for (int i = 0; i < gnt_log.size(); i++) chk("solo_gnt", gnt_log[i], 1);

    // Stall stream 0's response for four cycles.
    req_pixel = {5'h00, 5'h18, 5'h01};
    req_valid = 3'b001;
    step();
    req_valid = 3'b010;
    rsp_ready = 3'b110;
    repeat (4) step();
    chk("stall_total", stall_cnt, STATS ? 4 : 0);
    rsp_ready = 3'b111;
    step();
    req_valid = '0;
    step();

    // Fairness: 30 cycles of continuous requests from all streams.
    gnt_log.delete();
    for (int i = 0; i < N; i++) req_pixel[i*PW +: PW] = 5'($urandom_range(0, 31));
    req_valid = 3'b111;
    repeat (30) step();
    req_valid = '0;
    step();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (gnt_log[i]) cnt[gnt_log[i]]++;
    for (int i = 0; i < N; i++) chk("fair_count", cnt[i], 10);
    for (int i = 0; i + 1 < gnt_log.size(); i++)
      chk("fair_rotate", gnt_log[i+1], (gnt_log[i] + 1) % N);

    // Random traffic honouring the hold-until-ready rule.
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || m_last_gnt[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          req_pixel[i*PW +: PW] = 5'($urandom_range(0, 31));
        end
      for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 99) < 75);
      step();
    end

    // Reset with a lookup in flight.
    req_valid = '0; rsp_ready = '1;
    step();
    req_pixel = {5'h00, 5'h00, 5'h1F};
    req_valid = 3'b001;
    step();
    req_valid = '0;
    rsp_ready = 3'b110;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    rsp_ready = '1;
    step();
    gnt_log.delete();
    req_pixel = {5'h05, 5'h06, 5'h07};
    req_valid = 3'b111;
    step();
    req_valid = '0;
    step();
    chk("post_rst_len", gnt_log.size(), 1);
    if (gnt_log.size() > 0) chk("post_rst_first", gnt_log[0], 0);

    // NUM_REQ=2 instance, pixel 0 on both streams.
    r2_pixel = '0;
    r2_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("n2_ready", r2_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("n2_rsp_valid", r2_rsp_valid, (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
      if (k > 0) chk("n2_rsp_data", r2_rsp_data, 8'h00);
      @(posedge clk); #1;
    end
    r2_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/g_lut_arbiter.md
# g_lut_arbiter

Round-robin scheduler that time-shares one registered camera-response LUT (5-bit pixel in, 8-bit g value out, one-cycle latency, clock-enable held) between NUM_REQ exposure streams of the HDR pipeline. It sits between the per-exposure pixel unpackers and the radiance-weighting stage. It drives the LUT's pixel and clk_en inputs, tags each lookup with its requester, and returns the result with per-requester valid/ready backpressure.

## Interface
- NUM_REQ, 3, number of requesting exposure streams (2..8)
- PIX_W, 5, LUT index width
- DATA_W, 8, LUT data width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  lookup request per stream
- req_pixel  in  NUM_REQ*PIX_W  packed pixels, stream i at [i*PIX_W +: PIX_W]
- req_ready  out  NUM_REQ  one-hot grant; request consumed when valid&ready
- rsp_valid  out  NUM_REQ  one-hot result valid for stream i
- rsp_ready  in  NUM_REQ  per-stream result acceptance
- rsp_data  out  DATA_W  g value, shared bus, qualified by rsp_valid
- lut_pixel  out  PIX_W  LUT index
- lut_clk_en  out  1  LUT clock enable
- lut_data  in  DATA_W  LUT registered output
- stall_cnt  out  16  stall-cycle counter (see Configuration)

## Operation
- Two stages: S0 arbitration (combinational grant), S1 LUT output register plus tag register s1_tag and flag s1_valid.
- The pipeline advances when s1_valid is 0, or when rsp_ready[s1_tag] is 1. This value drives lut_clk_en directly.
- When advance is 0, the LUT holds its output and no grant is issued: req_ready is all 0 and lut_pixel holds 0.
- Grant: when the pipeline advances, the first requester with req_valid set wins. Search order starts at ptr+1 modulo NUM_REQ. ptr is updated to the winner only on a grant.
- lut_pixel is the winner's pixel, or 0 when there is no grant.
- On advance: s1_valid <= |grant and s1_tag <= winner index. A cycle with no grant bubbles the pipeline.
- rsp_valid[i] = s1_valid & (s1_tag == i). rsp_data = lut_data passthrough.
- Requesters must hold req_valid and req_pixel stable until req_ready is seen. The block relies on this and does not check it.
- Back-to-back: the same or different streams may be granted on consecutive cycles while responses are accepted, giving 1 lookup/cycle.

## Timing
- Latency: a grant in cycle N produces rsp_valid in cycle N+1.
- Reset values: s1_valid=0, s1_tag=0, ptr=NUM_REQ-1 (stream 0 has first priority), stall_cnt=0.
- During reset, outputs are rsp_valid=0, req_ready=0 and lut_pixel=0. lut_clk_en=1 because the pipeline is empty.
- Simultaneous response accept and new request: both occur in the same cycle. There is no bubble.
- Stall: while rsp_valid is asserted and rsp_ready for that stream is 0, rsp_data remains stable and the LUT is frozen.
- Reset mid-operation: any in-flight lookup is dropped silently. No response is issued, even though the LUT (which has no reset) retains stale data.
- Only one response is outstanding at a time, so responses complete in grant order.

## Configuration
- G_LUT_ARB_STATS_EN defined: stall_cnt increments each cycle that s1_valid=1 and advance=0. It saturates at 0xFFFF and clears only on reset.
- Not defined: stall_cnt is tied to 0 and no counter logic is generated. The port remains present.

## Structure
- Shared package g_lut_pkg contains PIX_W, DATA_W, the default NUM_REQ, and a requester-index type of width $clog2(NUM_REQ).
- Sub-module rr_arbiter(NUM_REQ): request vector, ptr and enable in; one-hot grant and encoded index out. It owns the ptr register.
- The LUT is instantiated outside this block and connected through the lut_* ports.

## Test plan
- After reset, assert req_valid=3'b111 with pixels 0x01/0x10/0x1F and rsp_ready all 1 → grants go to streams 0, 1, 2 on consecutive cycles; responses 0x09, 0x32, 0x51 arrive one cycle after each grant.
- Stream 1 alone requests pixel 0x18 continuously → one grant per cycle; rsp_valid=3'b010 with data 0x40 every cycle.
- Stall: rsp_ready[0]=0 for 4 cycles while the response to 0x01 is pending → data holds at 0x09, lut_clk_en=0 and req_ready=0 for 4 cycles; stall_cnt=4 when G_LUT_ARB_STATS_EN is defined, otherwise 0.
- Fairness: all 3 streams request continuously for 30 cycles → each is granted exactly 10 times, strictly rotating 0,1,2.
- Apply reset with a lookup in flight → no rsp_valid after reset; the first grant after reset goes to stream 0.
- NUM_REQ=2 build with pixel 0x00 on both streams → responses 0x00, 0x00, alternating grant 0, 1.
